// File: rtl/regfile_if.sv
// Decode/writeback-facing bundle of the register file: read ports, writeback,
// reservation and flush, plus scoreboard status.
interface regfile_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ok;
    logic            flush;
    logic [AW:0]     pend_cnt;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, pend_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ok, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// RV32I integer register file with two combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    localparam int RD_PORTS = 2;

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [AW:0]         pend_cnt;
    logic                rsv_ok;
    logic                rsv_take;

    function automatic logic [AW:0] popcnt(input logic [NUM_REGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++)
            c = c + (AW+1)'(v[i]);
        return c;
    endfunction

    // Read ports: x0 reads zero, same-cycle writeback wins over the array.
    logic [RD_PORTS-1:0][AW-1:0]   rd_addr;
    logic [RD_PORTS-1:0][XLEN-1:0] rd_data;
    logic [RD_PORTS-1:0]           rd_busy;
    logic [RD_PORTS-1:0]           rd_hit;

    assign rd_addr = {bus.rs2_addr, bus.rs1_addr};

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        assign rd_hit[p]  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == rd_addr[p]);
        assign rd_data[p] = (rd_addr[p] == '0) ? '0 :
                            rd_hit[p]          ? bus.wr_data : regs[rd_addr[p]];
        assign rd_busy[p] = busy[rd_addr[p]] & ~rd_hit[p];
    end

    assign bus.rs1_data = rd_data[0];
    assign bus.rs2_data = rd_data[1];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs2_busy = rd_busy[1];

    assign rsv_ok       = (bus.rsv_addr == '0) | ~busy[bus.rsv_addr];
    assign bus.rsv_ok   = rsv_ok;
    assign bus.pend_cnt = pend_cnt;

    // A reserve that lands on the register being retired this cycle is taken even
    // though rsv_ok shows the pre-edge bit: the younger instruction owns it.
    assign rsv_take = bus.rsv_en && (bus.rsv_addr != '0) &&
                      (rsv_ok || (bus.wr_en && bus.wr_addr == bus.rsv_addr));

    always_comb begin
        busy_nxt = busy;
        if (bus.flush) begin
            busy_nxt = '0;
        end else begin
            if (bus.wr_en)
                busy_nxt[bus.wr_addr] = 1'b0;
            if (rsv_take)
                busy_nxt[bus.rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            if (bus.wr_en && bus.wr_addr != '0)
                regs[bus.wr_addr] <= bus.wr_data;
            busy     <= busy_nxt;
            pend_cnt <= popcnt(busy_nxt);
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against an array-based
// model of the architectural registers and reservations.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_if #(.XLEN(32), .NUM_REGS(32)) bus ();

    regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model state: architectural values and reservation set.
    logic [31:0] mr [32];
    logic [31:0] mb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return mr[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return mb[a] && !(bus.wr_en && bus.wr_addr == a);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mr[i] = 32'd0;
            mb = 32'd0;
        end else begin
            logic ok, same;
            ok   = (bus.rsv_addr == 0) || !mb[bus.rsv_addr];
            same = bus.wr_en && (bus.wr_addr == bus.rsv_addr);
            if (bus.wr_en && bus.wr_addr != 0) mr[bus.wr_addr] = bus.wr_data;
            if (bus.flush) mb = 32'd0;
            else begin
                if (bus.wr_en) mb[bus.wr_addr] = 1'b0;
                if (bus.rsv_en && bus.rsv_addr != 0 && (ok || same)) mb[bus.rsv_addr] = 1'b1;
            end
            mb[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rs1_data", bus.rs1_data, exp_data(bus.rs1_addr));
            chk("rs2_data", bus.rs2_data, exp_data(bus.rs2_addr));
            chk("rs1_busy", 32'(bus.rs1_busy), 32'(exp_busy(bus.rs1_addr)));
            chk("rs2_busy", 32'(bus.rs2_busy), 32'(exp_busy(bus.rs2_addr)));
            chk("rsv_ok", 32'(bus.rsv_ok), 32'((bus.rsv_addr == 0) || !mb[bus.rsv_addr]));
            chk("pend_cnt", 32'(bus.pend_cnt), 32'($countones(mb)));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.rsv_en = 0; bus.flush = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.rs1_addr = 0; bus.rs2_addr = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rsv_addr = 0;
        idle();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state across every address.
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a); bus.rs2_addr = 5'(31 - a); bus.rsv_addr = 5'(a);
            settle();
            chk("rst_rs1_data", bus.rs1_data, 32'd0);
            chk("rst_rsv_ok", 32'(bus.rsv_ok), 32'd1);
            tick();
        end
        chk("rst_pend", 32'(bus.pend_cnt), 32'd0);

        // Write x5, bypass visible in write cycle; x0 write discarded.
        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF; bus.rs1_addr = 5;
        settle();
        chk("byp_x5", bus.rs1_data, 32'hDEADBEEF);
        tick();
        bus.wr_addr = 0; bus.wr_data = 32'h12345678;
        tick();
        idle(); bus.rs1_addr = 5; bus.rs2_addr = 0;
        settle();
        chk("rd_x5", bus.rs1_data, 32'hDEADBEEF);
        chk("rd_x0", bus.rs2_data, 32'd0);
        tick();

        // Reserve x7, then retire it.
        bus.rsv_en = 1; bus.rsv_addr = 7;
        tick();
        idle(); bus.rs1_addr = 7;
        settle();
        chk("x7_busy", 32'(bus.rs1_busy), 32'd1);
        chk("x7_rsv_ok", 32'(bus.rsv_ok), 32'd0);
        chk("x7_pend", 32'(bus.pend_cnt), 32'd1);
        tick();
        bus.wr_en = 1; bus.wr_addr = 7; bus.wr_data = 32'hA5;
        settle();
        chk("x7_byp_busy", 32'(bus.rs1_busy), 32'd0);
        chk("x7_byp_data", bus.rs1_data, 32'hA5);
        tick();
        idle();
        settle();
        chk("x7_ret_busy", 32'(bus.rs1_busy), 32'd0);
        chk("x7_ret_pend", 32'(bus.pend_cnt), 32'd0);
        tick();

        // Same-cycle retire+reserve of x9, busy beforehand.
        bus.rsv_en = 1; bus.rsv_addr = 9;
        tick();
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h99;
        settle();
        chk("x9_ok_pre", 32'(bus.rsv_ok), 32'd0);
        tick();
        idle(); bus.rs1_addr = 9;
        settle();
        chk("x9_busy_kept", 32'(bus.rs1_busy), 32'd1);
        chk("x9_data", bus.rs1_data, 32'h99);
        chk("x9_pend", 32'(bus.pend_cnt), 32'd1);
        tick();
        // Retire alone, then retire+reserve with x9 free.
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h98;
        tick();
        bus.wr_data = 32'h77; bus.rsv_en = 1; bus.rsv_addr = 9;
        tick();
        idle();
        settle();
        chk("x9_set", 32'(bus.rs1_busy), 32'd1);
        chk("x9_pend_inc", 32'(bus.pend_cnt), 32'd1);
        tick();
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h77;
        tick();
        idle();

        // Fill the scoreboard, then flush together with a reserve of x3.
        for (int r = 1; r < 32; r++) begin
            bus.rsv_en = 1; bus.rsv_addr = 5'(r);
            tick();
        end
        idle();
        settle();
        chk("full_pend", 32'(bus.pend_cnt), 32'd31);
        tick();
        bus.flush = 1; bus.rsv_en = 1; bus.rsv_addr = 3;
        tick();
        idle(); bus.rs1_addr = 5; bus.rs2_addr = 9; bus.rsv_addr = 3;
        settle();
        chk("flush_pend", 32'(bus.pend_cnt), 32'd0);
        chk("flush_x3_ok", 32'(bus.rsv_ok), 32'd1);
        chk("flush_x5", bus.rs1_data, 32'hDEADBEEF);
        chk("flush_x9", bus.rs2_data, 32'h77);
        tick();

        // Reset in the middle of a reserve run, with a concurrent write to x4.
        for (int r = 1; r <= 10; r++) begin
            bus.rsv_en = 1; bus.rsv_addr = 5'(r);
            if (r == 6) begin
                rst = 1; bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'hFF;
            end
            tick();
            if (r == 6) begin
                rst = 0; bus.wr_en = 0;
                idle(); bus.rs1_addr = 4; bus.rs2_addr = 5;
                settle();
                chk("rst_x4", bus.rs1_data, 32'd0);
                chk("rst_x5", bus.rs2_data, 32'd0);
                chk("rst_mid_pend", 32'(bus.pend_cnt), 32'd0);
                tick();
            end
        end
        idle();

        // Random traffic with a small hot address pool to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] pool [4];
            pool = '{5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rst          = ($urandom_range(0, 99) == 0);
            bus.flush    = ($urandom_range(0, 15) == 0);
            bus.wr_en    = $urandom_range(0, 1) == 1;
            bus.rsv_en   = $urandom_range(0, 1) == 1;
            bus.wr_addr  = pool[$urandom_range(0, 3)];
            bus.rsv_addr = pool[$urandom_range(0, 3)];
            bus.rs1_addr = pool[$urandom_range(0, 3)];
            bus.rs2_addr = pool[$urandom_range(0, 3)];
            bus.wr_data  = $urandom;
            tick();
        end
        rst = 0;
        idle();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised RV32I integer register file with two combinational read ports, one synchronous write port, optional write-to-read bypass and a per-register pending-write scoreboard. Sits between decode and writeback. Decode reserves a destination register at issue. Writeback retires the value and clears the reservation. Decode uses the busy flags to stall on RAW/WAW hazards. x0 is hardwired to zero and can never be reserved.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; must be a power of two ≥ 2.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and clears busy on read; 0 = no forwarding.
- AW, $clog2(NUM_REGS), address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  rs1_addr has an outstanding reservation.
- rs2_busy  out  1  rs2_addr has an outstanding reservation.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- rsv_en  in  1  reserve request from issue.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation of rsv_addr would be accepted this cycle.
- flush  in  1  drop all reservations (pipeline squash).
- pend_cnt  out  AW+1  number of registers currently reserved.

## Operation
- Storage: NUM_REGS × XLEN array `regs`, plus a NUM_REGS-bit vector `busy`.
- Write: on a clock edge with wr_en=1 and wr_addr≠0, `regs[wr_addr]` ← wr_data. Writes to address 0 are discarded.
- Read: rsN_data = 0 if rsN_addr=0.
  - Else, with BYPASS=1, wr_en=1 and wr_addr=rsN_addr, rsN_data = wr_data.
  - Else rsN_data = `regs[rsN_addr]`.
- Busy: rsN_busy = `busy[rsN_addr]`, masked to 0 when BYPASS=1, wr_en=1 and wr_addr=rsN_addr. `busy[0]` is always 0.
- rsv_ok = (rsv_addr=0) | ~`busy[rsv_addr]`, combinational. It is independent of rsv_en.
- Reservation: rsv_en=1, rsv_ok=1 and rsv_addr≠0 sets `busy[rsv_addr]` at the edge.
  - rsv_en with rsv_ok=0 is ignored; the issuer must hold and retry.
  - rsv_en to x0 is accepted with no effect.
- Retire: wr_en=1 clears `busy[wr_addr]` at the edge. A write to a register that is not busy is legal: data is written, busy stays 0.
- Priority for the busy bit of one address, highest first:
  1. rst
  2. flush (all bits → 0; rsv_en that cycle ignored)
  3. set by reservation
  4. clear by retire
- Retire and reserve to the same address in the same cycle: the bit ends at 1 (younger instruction owns it). rsv_ok for that cycle still reflects the pre-edge bit.
- flush does not affect `regs`. A wr_en in the flush cycle still writes data.
- pend_cnt: registered population count of `busy`, updated each edge to the next-state value. Range 0..NUM_REGS-1.

## Timing
- Reset (rst=1 at edge): all `regs` → 0, all `busy` → 0, pend_cnt → 0. The cycle after reset, rs1_data=rs2_data=0, rs1_busy=rs2_busy=0, rsv_ok=1.
- Reset mid-operation overrides any concurrent wr_en, rsv_en or flush.
- Read latency: 0 cycles, combinational from address.
- Write latency: 1 cycle. Data written at edge N is visible via the array from cycle N+1. With BYPASS=1 it is also visible in cycle N.
- Busy set at edge N is visible from cycle N+1. rsv_ok also drops in cycle N+1, so back-to-back reservations of the same register are refused.
- pend_cnt is consistent with `busy` in every cycle after any edge.
- All outputs depend only on current inputs and state. There is no other pipelining.

## Test plan
- Reset, then read all addresses: every rs1_data/rs2_data = 0, busy = 0, pend_cnt = 0.
- Write x5=0xDEADBEEF, then x0=0x12345678; next cycle read rs1=5, rs2=0: rs1_data=0xDEADBEEF, rs2_data=0. With BYPASS=1, rs1=5 in the write cycle also returns 0xDEADBEEF.
- Reserve x7: next cycle rs1_busy=1 for rs1=7, rsv_ok=0 for rsv_addr=7, pend_cnt=1. Retire x7=0xA5: with BYPASS=1 busy reads 0 in that cycle; in the following cycle busy=0 and pend_cnt=0.
- Same-cycle retire and reserve of x9, both active with x9 busy beforehand: x9 data updated and `busy[9]` stays 1. With x9 not busy beforehand: bit set and pend_cnt increments by 1.
- Reserve x1..x31 over 31 cycles: pend_cnt=31. Then flush together with rsv_en to x3: pend_cnt=0 next cycle, all busy=0, register data unchanged.
- Assert rst in the middle of the previous sequence, concurrent with wr_en to x4=0xFF: x4 reads 0 and pend_cnt=0 afterwards.
